// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths and writeback request type
package cpu_pkg;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_W;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        reg_onehot    = '0;
        reg_onehot[r] = 1'b1;
    endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter bus: ALU/load/memory inputs, RF write and hazard outputs
interface wb_arbiter_if #(
    parameter int LD_Q = 4
);
    import cpu_pkg::*;

    logic                   alu_vld;
    logic [REG_W-1:0]       alu_dst_addr;
    logic [DATA_W-1:0]      alu_rslt;
    logic                   ld_issue;
    logic [REG_W-1:0]       ld_dst_addr;
    logic                   mem_rd_vld;
    logic [DATA_W-1:0]      mem_data;
    logic                   rf_we;
    logic [REG_W-1:0]       rf_dst_addr;
    logic [DATA_W-1:0]      rf_wdata;
    logic                   stall_ex;
    logic [NUM_REGS-1:0]    ld_busy;
    logic [$clog2(LD_Q):0]  ld_cnt;
    logic                   proto_err;

    modport master (
        output alu_vld, alu_dst_addr, alu_rslt, ld_issue, ld_dst_addr, mem_rd_vld, mem_data,
        input  rf_we, rf_dst_addr, rf_wdata, stall_ex, ld_busy, ld_cnt, proto_err
    );

    modport slave (
        input  alu_vld, alu_dst_addr, alu_rslt, ld_issue, ld_dst_addr, mem_rd_vld, mem_data,
        output rf_we, rf_dst_addr, rf_wdata, stall_ex, ld_busy, ld_cnt, proto_err
    );
endinterface

// File: rtl/dst_mux.sv
// rtl/dst_mux.sv - writeback data select between ALU result and data-memory load data
module dst_mux
    import cpu_pkg::*;
(
    input  logic              dm_re_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic [DATA_W-1:0] data_o
);
    assign data_o = dm_re_i ? dm_data_i : alu_data_i;
endmodule

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO with occupancy count and flat view of all entries
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   cnt_o,
    output logic [DEPTH*WIDTH-1:0]   entries_o,
    output logic [DEPTH-1:0]         entry_vld_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign cnt_o  = cnt_q;

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [AW-1:0] age;
        assign age                         = AW'(i) - rd_ptr_q;
        assign entries_o[i*WIDTH +: WIDTH] = mem_q[i];
        assign entry_vld_o[i]              = {1'b0, age} < cnt_q;
    end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - schedules the RF write port between load returns and ALU results
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int ALU_Q = 2,
    parameter int LD_Q  = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int ACW = $clog2(ALU_Q) + 1;
    localparam int LCW = $clog2(LD_Q) + 1;
    localparam logic [ACW-1:0] ALU_FULL = ACW'(ALU_Q);
    localparam logic [LCW-1:0] LD_FULL  = LCW'(LD_Q);

    logic [ACW-1:0]                  alu_cnt;
    logic [LCW-1:0]                  ld_cnt;
    wb_req_t                         alu_push_req, alu_head;
    logic                            alu_push, alu_pop, ld_pop;
    logic [REG_W-1:0]                ld_head;
    logic [LD_Q*REG_W-1:0]           ld_entries;
    logic [LD_Q-1:0]                 ld_vld;
    logic [ALU_Q*(REG_W+DATA_W)-1:0] alu_entries_unused;
    logic [ALU_Q-1:0]                alu_vld_unused;
    logic                            stall, alu_acc, ld_acc, ld_ret;
    logic                            win, dm_re;
    logic [REG_W-1:0]                win_addr;
    logic [DATA_W-1:0]               win_alu_data, mux_data;
    logic [NUM_REGS-1:0]             ld_busy;

    logic                            rf_we_q, rf_we_d;
    logic [REG_W-1:0]                rf_dst_addr_q, rf_dst_addr_d;
    logic [DATA_W-1:0]               rf_wdata_q, rf_wdata_d;
    logic                            proto_err_q, proto_err_d;

    // Stall looks only at registered counts, so a pop in the same cycle does not release it.
    assign stall        = (alu_cnt == ALU_FULL) | (ld_cnt == LD_FULL);
    assign alu_acc      = bus.alu_vld & ~stall;
    assign ld_acc       = bus.ld_issue & ~stall;
    assign ld_ret       = bus.mem_rd_vld & (ld_cnt != '0);
    assign alu_push     = alu_acc & (ld_ret | (alu_cnt != '0));
    assign alu_push_req = '{addr: bus.alu_dst_addr, data: bus.alu_rslt};

    wb_fifo #(.WIDTH(REG_W + DATA_W), .DEPTH(ALU_Q)) u_alu_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (alu_push),
        .push_data_i (alu_push_req),
        .pop_i       (alu_pop),
        .head_o      (alu_head),
        .cnt_o       (alu_cnt),
        .entries_o   (alu_entries_unused),
        .entry_vld_o (alu_vld_unused)
    );

    wb_fifo #(.WIDTH(REG_W), .DEPTH(LD_Q)) u_ld_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ld_acc),
        .push_data_i (bus.ld_dst_addr),
        .pop_i       (ld_pop),
        .head_o      (ld_head),
        .cnt_o       (ld_cnt),
        .entries_o   (ld_entries),
        .entry_vld_o (ld_vld)
    );

    always_comb begin
        win          = 1'b0;
        dm_re        = 1'b0;
        ld_pop       = 1'b0;
        alu_pop      = 1'b0;
        win_addr     = '0;
        win_alu_data = alu_head.data;
        if (ld_ret) begin
            win      = 1'b1;
            dm_re    = 1'b1;
            ld_pop   = 1'b1;
            win_addr = ld_head;
        end else if (alu_cnt != '0) begin
            win      = 1'b1;
            alu_pop  = 1'b1;
            win_addr = alu_head.addr;
        end else if (alu_acc) begin
            win          = 1'b1;
            win_addr     = bus.alu_dst_addr;
            win_alu_data = bus.alu_rslt;
        end
    end

    dst_mux u_dst_mux (
        .dm_re_i    (dm_re),
        .alu_data_i (win_alu_data),
        .dm_data_i  (bus.mem_data),
        .data_o     (mux_data)
    );

    always_comb begin
        rf_we_d       = win && (win_addr != '0);
        rf_dst_addr_d = rf_dst_addr_q;
        rf_wdata_d    = rf_wdata_q;
        if (win) begin
            rf_dst_addr_d = win_addr;
            rf_wdata_d    = mux_data;
        end
        proto_err_d = proto_err_q | (bus.mem_rd_vld & (ld_cnt == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q       <= 1'b0;
            rf_dst_addr_q <= '0;
            rf_wdata_q    <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            rf_we_q       <= rf_we_d;
            rf_dst_addr_q <= rf_dst_addr_d;
            rf_wdata_q    <= rf_wdata_d;
            proto_err_q   <= proto_err_d;
        end
    end

    always_comb begin
        ld_busy = '0;
        for (int i = 0; i < LD_Q; i++) begin
            if (ld_vld[i]) begin
                ld_busy = ld_busy | reg_onehot(ld_entries[i*REG_W +: REG_W]);
            end
        end
    end

    assign bus.rf_we       = rf_we_q;
    assign bus.rf_dst_addr = rf_dst_addr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.stall_ex    = stall;
    assign bus.ld_busy     = ld_busy;
    assign bus.ld_cnt      = ld_cnt;
    assign bus.proto_err   = proto_err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
    import cpu_pkg::*;

    localparam int ALU_Q = 2;
    localparam int LD_Q  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.LD_Q(LD_Q)) bus();

    wb_arbiter #(.ALU_Q(ALU_Q), .LD_Q(LD_Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             e;
    wb_req_t          alu_pend[$];
    logic [REG_W-1:0] ld_tags[$];
    logic             mdl_proto = 1'b0;
    logic             post_rst  = 1'b0;
    int               cyc   = 0;
    int               n_chk = 0;
    int               n_err = 0;

    logic             snap_stall, snap_proto, snap_rf_zero;
    int               snap_ldcnt;
    logic [31:0]      snap_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic emit(input logic [REG_W-1:0] a, input logic [DATA_W-1:0] d);
        if (a != '0) exp_q.push_back('{addr: a, data: d, due: cyc + 1});
    endtask

    // One clock of stimulus; the model advances to the state after the coming edge.
    task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic li, input logic [4:0] la, input logic mv, input logic [31:0] md);
        logic             won;
        wb_req_t          req;
        logic [REG_W-1:0] t;
        @(posedge clk);
        #1;
        cyc++;
        snap_stall   = (alu_pend.size() == ALU_Q) || (ld_tags.size() == LD_Q);
        snap_ldcnt   = ld_tags.size();
        snap_proto   = mdl_proto;
        snap_busy    = '0;
        foreach (ld_tags[i]) snap_busy[ld_tags[i]] = 1'b1;
        snap_rf_zero = post_rst;
        post_rst     = r;

        rst              = r;
        bus.alu_vld      = av;
        bus.alu_dst_addr = aa;
        bus.alu_rslt     = ad;
        bus.ld_issue     = li;
        bus.ld_dst_addr  = la;
        bus.mem_rd_vld   = mv;
        bus.mem_data     = md;

        if (r) begin
            alu_pend.delete();
            ld_tags.delete();
            mdl_proto = 1'b0;
        end else begin
            won = 1'b0;
            if (mv) begin
                if (ld_tags.size() > 0) begin
                    t = ld_tags.pop_front();
                    emit(t, md);
                    won = 1'b1;
                end else begin
                    mdl_proto = 1'b1;
                end
            end
            if (!won && alu_pend.size() > 0) begin
                req = alu_pend.pop_front();
                emit(req.addr, req.data);
                won = 1'b1;
            end
            if (av && !snap_stall) begin
                if (!won) emit(aa, ad);
                else alu_pend.push_back('{addr: aa, data: ad});
            end
            if (li && !snap_stall) ld_tags.push_back(la);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Monitor: every write is popped from the scoreboard on exactly its due cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 2) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    check("rf_we", bus.rf_we, 1);
                    check("rf_dst_addr", bus.rf_dst_addr, e.addr);
                    check("rf_wdata", bus.rf_wdata, e.data);
                end else begin
                    check("rf_we_idle", bus.rf_we, 0);
                end
                check("stall_ex", bus.stall_ex, snap_stall);
                check("ld_cnt", bus.ld_cnt, snap_ldcnt);
                check("ld_busy", bus.ld_busy, snap_busy);
                check("proto_err", bus.proto_err, snap_proto);
                if (snap_rf_zero) begin
                    check("rst_rf_dst_addr", bus.rf_dst_addr, 0);
                    check("rst_rf_wdata", bus.rf_wdata, 0);
                end
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.alu_vld      = 1'b0;
        bus.alu_dst_addr = '0;
        bus.alu_rslt     = '0;
        bus.ld_issue     = 1'b0;
        bus.ld_dst_addr  = '0;
        bus.mem_rd_vld   = 1'b0;
        bus.mem_data     = '0;

        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        idle(); sample();
        check("reset_rf_we", bus.rf_we, 0);
        check("reset_addr", bus.rf_dst_addr, 0);
        check("reset_wdata", bus.rf_wdata, 0);
        check("reset_stall", bus.stall_ex, 0);
        check("reset_busy", bus.ld_busy, 0);
        check("reset_ld_cnt", bus.ld_cnt, 0);
        check("reset_proto", bus.proto_err, 0);
        idle(); idle();

        // Lone ALU result: one-cycle latency
        step(1'b0, 1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 1'b0, 32'd0);
        idle(); sample();
        check("lone_we", bus.rf_we, 1);
        check("lone_addr", bus.rf_dst_addr, 3);
        check("lone_data", bus.rf_wdata, 32'h1234);
        idle(); sample();
        check("lone_after_we", bus.rf_we, 0);

        // Load return beats a same-cycle ALU result
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 32'd0);
        step(1'b0, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 1'b1, 32'hAAAA_0000);
        idle(); sample();
        check("coll_ld_addr", bus.rf_dst_addr, 4);
        check("coll_ld_data", bus.rf_wdata, 32'hAAAA_0000);
        idle(); sample();
        check("coll_alu_addr", bus.rf_dst_addr, 5);
        check("coll_alu_data", bus.rf_wdata, 32'h55);

        // Load FIFO full
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0);
        sample();
        check("full_stall", bus.stall_ex, 1);
        check("full_ld_cnt", bus.ld_cnt, 4);
        idle(); sample();
        check("full_fifth_ignored", bus.ld_cnt, 4);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h100);
        sample();
        check("full_stall_same_cycle", bus.stall_ex, 1);
        idle(); sample();
        check("full_stall_released", bus.stall_ex, 0);
        check("full_ld_cnt_3", bus.ld_cnt, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h200 + 32'(i));
        idle();

        // Busy mask with repeated loads to one register, and a load to r0
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h7A);
        idle(); sample();
        check("busy7_one_left", bus.ld_busy[7], 1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h7B);
        idle(); sample();
        check("busy7_clear", bus.ld_busy[7], 0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 32'd0);
        idle(); sample();
        check("busy0_set", bus.ld_busy[0], 1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hDEAD);
        idle(); sample();
        check("r0_no_write", bus.rf_we, 0);

        // Return with nothing outstanding
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hBAD);
        idle(); sample();
        check("proto_set", bus.proto_err, 1);
        check("proto_no_write", bus.rf_we, 0);
        idle(); idle(); idle(); sample();
        check("proto_sticky", bus.proto_err, 1);

        // Reset with loads outstanding and the ALU queue full
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 32'd0);
        step(1'b0, 1'b1, 5'd10, 32'hA1, 1'b1, 5'd3, 1'b1, 32'h11);
        step(1'b0, 1'b1, 5'd11, 32'hB2, 1'b1, 5'd4, 1'b1, 32'h22);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        sample();
        check("pre_rst_stall", bus.stall_ex, 1);
        check("pre_rst_ld_cnt", bus.ld_cnt, 2);
        idle(); sample();
        check("midrst_we", bus.rf_we, 0);
        check("midrst_addr", bus.rf_dst_addr, 0);
        check("midrst_data", bus.rf_wdata, 0);
        check("midrst_busy", bus.ld_busy, 0);
        check("midrst_stall", bus.stall_ex, 0);
        check("midrst_ld_cnt", bus.ld_cnt, 0);
        check("midrst_proto", bus.proto_err, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
            end else begin
                step(1'b0, $urandom_range(0, 99) < 40, 5'($urandom), $urandom,
                     $urandom_range(0, 99) < 30, 5'($urandom),
                     $urandom_range(0, 99) < 35, $urandom);
            end
        end
        for (int i = 0; i < 10; i++) idle();
        sample();
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
